mul_seq_ctrl: RTL and testbench

Issue/writeback controller for the 4-stage pipelined integer multiplier (`Execute` stages S_ID=0..3 chained).
- Accepts multiply micro-ops from the issue stage over a valid/ready handshake and drives stage 0.
- Tracks valid bit and destination tag alongside the non-stallable multiplier pipeline, and captures each result into an in-order result buffer.
- Presents results to writeback over a valid/ready handshake.
- Backpressure uses credits, so no result leaving the free-running pipeline is ever dropped.

---
 rtl/mul_pkg.sv | 10 +
 rtl/mul_rbuf.sv | 60 ++++++
 rtl/mul_seq_ctrl.sv | 101 ++++++++++
 tb/tb_mul_seq_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared micro-op codes and defaults for the pipelined multiplier controller.
package mul_pkg;
   localparam logic [5:0] NOP    = 6'b000_000;
   localparam logic [5:0] MUL    = 6'b001_000;
   localparam logic [5:0] MULH   = 6'b001_001;
   localparam logic [5:0] MULHSU = 6'b001_010;
   localparam logic [5:0] MULHU  = 6'b001_011;

   localparam int S_STG_DFLT = 4;
endpackage

// File: rtl/mul_rbuf.sv
// In-order result buffer: synchronous FIFO with a registered head so writeback
// sees tag/data straight from flops.
module mul_rbuf
   import mul_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 37
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic [WIDTH-1:0] head_reg;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~clr;
   assign do_pop  = pop & ~clr & ~empty;
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign head    = head_reg;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= '0;
      end else if (clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
         // New entry bypasses memory when it becomes the head this cycle.
         if (do_push && (empty || (do_pop && count_reg == (AW+1)'(1))))
            head_reg <= din;
         else if (do_pop)
            head_reg <= mem[rd_ptr_reg + AW'(1)];
      end
   end
endmodule

// File: rtl/mul_seq_ctrl.sv
// Issue/writeback controller for the free-running multiplier pipeline: tracks
// valid/tag beside the pipe and buffers results, with credit-based backpressure.
module mul_seq_ctrl
   import mul_pkg::*;
#(
   parameter int W_PD_UOPS  = 6,
   parameter int W_PD_DATA  = 32,
   parameter int W_PD_PDATA = 2*W_PD_DATA,
   parameter int S_STG      = S_STG_DFLT,
   parameter int W_TAG      = 5,
   parameter int D_RBUF     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ISS_valid,
   output logic                  ISS_ready,
   input  logic [W_PD_UOPS-1:0]  ISS_uops,
   input  logic [W_PD_DATA-1:0]  ISS_rs,
   input  logic [W_PD_DATA-1:0]  ISS_rt,
   input  logic [W_TAG-1:0]      ISS_tag,
   input  logic                  FLUSH,
   output logic [W_PD_UOPS-1:0]  PIP_uops,
   output logic [W_PD_PDATA-1:0] PIP_rs,
   output logic [W_PD_PDATA-1:0] PIP_rt,
   input  logic [W_PD_PDATA-1:0] PIP_rp,
   output logic                  WB_valid,
   input  logic                  WB_ready,
   output logic [W_TAG-1:0]      WB_tag,
   output logic [W_PD_DATA-1:0]  WB_data
);
   localparam int W_ENT  = W_TAG + W_PD_DATA;
   localparam int W_USED = $clog2(D_RBUF + 1);

   logic                          acc;
   logic                          pop;
   logic                          full;
   logic                          empty;
   logic [W_USED-1:0]             used_reg;
   logic [S_STG-1:0]              trk_vld_reg;
   logic [S_STG-1:0]              trk_vld_next;
   logic [S_STG-1:0][W_TAG-1:0]   trk_tag_reg;
   logic [S_STG-1:0][W_TAG-1:0]   trk_tag_next;
   logic [W_ENT-1:0]              head;
   logic                          unused_rp_hi;

   // Credits cover both in-flight and buffered ops, so the buffer cannot overflow.
   assign ISS_ready = (used_reg < W_USED'(D_RBUF)) & ~FLUSH;
   assign acc       = ISS_valid & ISS_ready;
   assign pop       = WB_valid & WB_ready;

   assign PIP_uops = acc ? ISS_uops : NOP;
   assign PIP_rs   = acc ? W_PD_PDATA'(ISS_rs) : '0;
   assign PIP_rt   = acc ? W_PD_PDATA'(ISS_rt) : '0;

   assign trk_vld_next[0] = acc;
   assign trk_tag_next[0] = ISS_tag;

   genvar gi;
   generate
      for (gi = 1; gi < S_STG; gi++) begin : g_trk
         assign trk_vld_next[gi] = trk_vld_reg[gi-1];
         assign trk_tag_next[gi] = trk_tag_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trk_vld_reg <= '0;
         trk_tag_reg <= '0;
         used_reg    <= '0;
      end else begin
         trk_vld_reg <= FLUSH ? '0 : trk_vld_next;
         trk_tag_reg <= trk_tag_next;
         used_reg    <= FLUSH ? '0 : used_reg + W_USED'(acc) - W_USED'(pop);
      end
   end

   // Half selection happens inside the multiplier; only the low word is meaningful.
   assign unused_rp_hi = ^PIP_rp[W_PD_PDATA-1:W_PD_DATA];

   mul_rbuf #(
      .DEPTH (D_RBUF),
      .WIDTH (W_ENT)
   ) u_rbuf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (trk_vld_reg[S_STG-1]),
      .pop   (pop),
      .clr   (FLUSH),
      .din   ({trk_tag_reg[S_STG-1], PIP_rp[W_PD_DATA-1:0]}),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   assign WB_valid = ~empty;
   assign {WB_tag, WB_data} = head;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(trk_vld_reg[S_STG-1] && full && !FLUSH));
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural 4-stage multiplier and an
// in-order scoreboard that also predicts ISS_ready and WB_valid every cycle.
module tb_mul_seq_ctrl;
   import mul_pkg::*;

   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ISS_valid = 1'b0;
   logic        ISS_ready;
   logic [5:0]  ISS_uops = NOP;
   logic [31:0] ISS_rs = '0;
   logic [31:0] ISS_rt = '0;
   logic [4:0]  ISS_tag = '0;
   logic        FLUSH = 1'b0;
   logic [5:0]  PIP_uops;
   logic [63:0] PIP_rs;
   logic [63:0] PIP_rt;
   logic [63:0] PIP_rp;
   logic        WB_valid;
   logic        WB_ready = 1'b0;
   logic [4:0]  WB_tag;
   logic [31:0] WB_data;

   mul_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ISS_valid (ISS_valid),
      .ISS_ready (ISS_ready),
      .ISS_uops  (ISS_uops),
      .ISS_rs    (ISS_rs),
      .ISS_rt    (ISS_rt),
      .ISS_tag   (ISS_tag),
      .FLUSH     (FLUSH),
      .PIP_uops  (PIP_uops),
      .PIP_rs    (PIP_rs),
      .PIP_rt    (PIP_rt),
      .PIP_rp    (PIP_rp),
      .WB_valid  (WB_valid),
      .WB_ready  (WB_ready),
      .WB_tag    (WB_tag),
      .WB_data   (WB_data)
   );

   always #5 clk = ~clk;

   // Reference multiplier: selected half in the low word, junk in the high word.
   function automatic logic [63:0] mul_model(input logic [5:0] u, input logic [63:0] rs, input logic [63:0] rt);
      logic [31:0]        a;
      logic [31:0]        b;
      logic [63:0]        pu;
      logic signed [63:0] ps;
      logic signed [63:0] psu;
      logic [31:0]        r;
      a   = rs[31:0];
      b   = rt[31:0];
      pu  = {32'b0, a} * {32'b0, b};
      ps  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      psu = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
      case (u)
         MUL:     r = pu[31:0];
         MULH:    r = ps[63:32];
         MULHSU:  r = psu[63:32];
         default: r = pu[63:32];
      endcase
      return {~r, r};
   endfunction

   logic [63:0] pipe [4];
   always @(posedge clk) begin
      pipe[0] <= mul_model(PIP_uops, PIP_rs, PIP_rt);
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
   end
   assign PIP_rp = pipe[3];

   typedef struct {
      logic [4:0]  tag;
      logic [31:0] data;
      int          due;
   } sb_t;

   sb_t         sb[$];
   logic [4:0]  pop_tags[$];
   logic [31:0] pop_data[$];
   int          pop_cyc[$];
   int          model_used = 0;
   int          cyc = 0;
   logic        last_acc = 1'b0;
   int          n_pass = 0;
   int          n_total = 0;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
   endtask

   // One clock: score at the falling edge, then advance to 1ns past the rising edge.
   task automatic step();
      logic exp_ready;
      logic exp_valid;
      logic acc;
      logic pop;
      sb_t  e;
      @(negedge clk);
      last_acc = 1'b0;
      if (!rst_n) begin
         sb.delete();
         model_used = 0;
      end else begin
         exp_ready = (model_used < D) && !FLUSH;
         chk("iss_ready", ISS_ready, exp_ready);
         exp_valid = (sb.size() > 0) && (sb[0].due <= cyc);
         chk("wb_valid", WB_valid, exp_valid);
         acc = ISS_valid && exp_ready;
         pop = exp_valid && WB_ready && !FLUSH;
         if (pop) begin
            e = sb.pop_front();
            chk("wb_tag", WB_tag, e.tag);
            chk("wb_data", WB_data, e.data);
            pop_tags.push_back(WB_tag);
            pop_data.push_back(WB_data);
            pop_cyc.push_back(cyc);
            $display("cyc %0d pop  tag=%0d data=%08h", cyc, WB_tag, WB_data);
         end
         if (FLUSH) begin
            sb.delete();
            model_used = 0;
         end else begin
            if (acc) begin
               e.tag  = ISS_tag;
               e.data = mul_model(ISS_uops, {32'b0, ISS_rs}, {32'b0, ISS_rt})[31:0];
               e.due  = cyc + 5;
               sb.push_back(e);
               last_acc = 1'b1;
               $display("cyc %0d acc  tag=%0d uop=%06b rs=%08h rt=%08h", cyc, ISS_tag, ISS_uops, ISS_rs, ISS_rt);
            end
            model_used = model_used + int'(acc) - int'(pop);
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic issue(input logic [5:0] u, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
      ISS_valid = 1'b1;
      ISS_uops  = u;
      ISS_rs    = a;
      ISS_rt    = b;
      ISS_tag   = t;
      step();
   endtask

   task automatic idle(input int n);
      ISS_valid = 1'b0;
      ISS_uops  = NOP;
      repeat (n) step();
   endtask

   task automatic clear_log();
      pop_tags.delete();
      pop_data.delete();
      pop_cyc.delete();
   endtask

   initial begin
      int n;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_iss_ready", ISS_ready, 1'b1);
      chk("rst_wb_valid", WB_valid, 1'b0);
      chk("rst_wb_tag", WB_tag, 5'd0);
      chk("rst_wb_data", WB_data, 32'd0);
      chk("rst_pip_uops", PIP_uops, NOP);
      chk("rst_pip_rs", PIP_rs, 64'd0);
      chk("rst_pip_rt", PIP_rt, 64'd0);
      rst_n = 1'b1;
      step();

      // Single MUL, 5-cycle latency
      WB_ready  = 1'b1;
      ISS_valid = 1'b1;
      ISS_uops  = MUL;
      ISS_rs    = 32'd7;
      ISS_rt    = 32'd6;
      ISS_tag   = 5'd3;
      #1;
      chk("pip_uops_acc", PIP_uops, MUL);
      chk("pip_rs_acc", PIP_rs, 64'd7);
      chk("pip_rt_acc", PIP_rt, 64'd6);
      step();
      idle(4);
      chk("pip_uops_idle", PIP_uops, NOP);
      chk("mul_wb_valid_c5", WB_valid, 1'b1);
      chk("mul_wb_tag", WB_tag, 5'd3);
      chk("mul_wb_data", WB_data, 32'd42);
      idle(2);

      // Back-to-back high-half variants plus an illegal uop
      clear_log();
      issue(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
      issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11);
      issue(MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd12);
      issue(6'b111_111, 32'h8000_0000, 32'd4, 5'd13);
      idle(10);
      chk("b2b_count", 64'(pop_data.size()), 64'd4);
      chk("mulh_data", pop_data[0], 32'h0000_0000);
      chk("mulhu_data", pop_data[1], 32'hFFFF_FFFE);
      chk("mulhsu_data", pop_data[2], 32'hFFFF_FFFF);
      chk("illegal_data", pop_data[3], 32'h0000_0002);
      chk("b2b_consecutive", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);

      // Buffer full: WB_ready low, tags 0..9
      clear_log();
      WB_ready = 1'b0;
      for (int t = 0; t < D; t++) issue(MUL, 32'(t), 32'd3, 5'(t));
      ISS_valid = 1'b1;
      ISS_tag   = 5'd8;
      ISS_rs    = 32'd8;
      repeat (6) step();
      chk("full_iss_ready", ISS_ready, 1'b0);
      chk("full_used", dut.used_reg, 64'(D));
      WB_ready = 1'b1;
      for (int t = 8; t < 10; t++) begin
         ISS_tag = 5'(t);
         ISS_rs  = 32'(t);
         n = 0;
         do begin
            step();
            n++;
         end while (!last_acc && n < 30);
         chk("full_accept_bound", last_acc, 1'b1);
      end
      idle(12);
      chk("full_pop_count", 64'(pop_tags.size()), 64'd10);
      for (int t = 0; t < 10; t++) chk("full_pop_order", pop_tags[t], 5'(t));

      // Simultaneous accept and pop at used = D-1
      WB_ready = 1'b0;
      for (int t = 0; t < D - 1; t++) issue(MUL, 32'(t), 32'd5, 5'(20 + t));
      idle(6);
      chk("pre_sim_used", dut.used_reg, 64'(D - 1));
      WB_ready = 1'b1;
      issue(MUL, 32'd3, 32'd4, 5'd27);
      ISS_valid = 1'b0;
      chk("sim_used", dut.used_reg, 64'(D - 1));
      chk("sim_iss_ready", ISS_ready, 1'b1);
      idle(14);

      // FLUSH with 2 buffered and 3 in flight, plus an offered op that must not enter
      WB_ready = 1'b0;
      issue(MUL, 32'd1, 32'd1, 5'd1);
      issue(MUL, 32'd2, 32'd2, 5'd2);
      idle(3);
      issue(MUL, 32'd3, 32'd3, 5'd3);
      issue(MUL, 32'd4, 32'd4, 5'd4);
      issue(MUL, 32'd5, 32'd5, 5'd5);
      chk("pre_flush_wb_valid", WB_valid, 1'b1);
      clear_log();
      FLUSH     = 1'b1;
      ISS_valid = 1'b1;
      ISS_tag   = 5'd6;
      #1;
      chk("flush_iss_ready", ISS_ready, 1'b0);
      step();
      FLUSH     = 1'b0;
      ISS_valid = 1'b0;
      WB_ready  = 1'b1;
      chk("post_flush_wb_valid", WB_valid, 1'b0);
      chk("post_flush_used", dut.used_reg, 64'd0);
      idle(10);
      chk("flush_no_pops", 64'(pop_tags.size()), 64'd0);
      issue(MUL, 32'd9, 32'd9, 5'd7);
      idle(7);
      chk("post_flush_pop_count", 64'(pop_tags.size()), 64'd1);
      chk("post_flush_tag", pop_tags[0], 5'd7);
      chk("post_flush_data", pop_data[0], 32'd81);

      // Asynchronous reset while ops are buffered and in flight
      WB_ready = 1'b0;
      issue(MUL, 32'd2, 32'd3, 5'd15);
      issue(MUL, 32'd4, 32'd5, 5'd16);
      issue(MUL, 32'd6, 32'd7, 5'd17);
      idle(4);
      chk("pre_rst_wb_valid", WB_valid, 1'b1);
      clear_log();
      rst_n = 1'b0;
      sb.delete();
      model_used = 0;
      #1;
      chk("mid_rst_wb_valid", WB_valid, 1'b0);
      chk("mid_rst_wb_tag", WB_tag, 5'd0);
      chk("mid_rst_wb_data", WB_data, 32'd0);
      chk("mid_rst_iss_ready", ISS_ready, 1'b1);
      chk("mid_rst_used", dut.used_reg, 64'd0);
      chk("mid_rst_pip_uops", PIP_uops, NOP);
      repeat (2) step();
      rst_n    = 1'b1;
      WB_ready = 1'b1;
      idle(10);
      chk("rst_no_pops", 64'(pop_tags.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
